// File: rtl/filler_pkg.sv
// Shared encodings for the framebuffer test-pattern writer.
package filler_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_RECT    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_HGRAD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y/linear-address counters; addr tracks y*H_RES+x by increment.
module raster_counter
  import filler_pkg::*;
#(
  parameter  int H_RES      = 160,
  parameter  int V_RES      = 120,
  parameter  int ADDR_WIDTH = 15,
  localparam int XW         = $clog2(H_RES),
  localparam int YW         = $clog2(V_RES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  adv_i,
  output logic [XW-1:0]         x_nxt_o,
  output logic [YW-1:0]         y_nxt_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_RES - 1);

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  assign last_o = (x_q == XMAX) && (y_q == YMAX);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = last_o ? '0 : addr_q + ADDR_WIDTH'(1);
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = (y_q == YMAX) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_nxt_o = x_d;
  assign y_nxt_o = y_d;
  assign addr_o  = addr_q;

endmodule

// File: rtl/pattern_filler.sv
// Framebuffer test-pattern writer: solid/rect/checker/hgrad raster fill.
// Define FILLER_CHECKER_EN to build the checkerboard; otherwise mode 2 = solid.
module pattern_filler
  import filler_pkg::*;
#(
  parameter  int H_RES      = 160,
  parameter  int V_RES      = 120,
  parameter  int ADDR_WIDTH = 15,
  parameter  int PIX_W      = 1,
  parameter  int CHK_LOG2   = 3,
  localparam int XW         = $clog2(H_RES),
  localparam int YW         = $clog2(V_RES)
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic [1:0]            mode,
  input  logic [PIX_W-1:0]      fg,
  input  logic [PIX_W-1:0]      bg,
  input  logic [XW-1:0]         x0,
  input  logic [XW-1:0]         x1,
  input  logic [YW-1:0]         y0,
  input  logic [YW-1:0]         y1,
  input  logic                  wr_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [PIX_W-1:0]      pixel,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            frame_cnt
);

  if ((H_RES * V_RES > 2 ** ADDR_WIDTH) || (CHK_LOG2 >= YW)) begin : g_bad_cfg
    $error("pattern_filler: bad parameter set");
  end

  state_e             state_q, state_d;
  mode_e              mode_q, mode_s;
  logic [PIX_W-1:0]   fg_q, bg_q, fg_s, bg_s;
  logic [XW-1:0]      x0_q, x1_q, x0_s, x1_s, x_nxt;
  logic [YW-1:0]      y0_q, y1_q, y0_s, y1_s, y_nxt;
  logic               we_q, we_d, busy_q, done_q, done_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ld, acc, last, adv, clr, load_pix;

  function automatic logic [PIX_W-1:0] pix_fn(
    input mode_e            m,
    input logic [PIX_W-1:0] f,
    input logic [PIX_W-1:0] b,
    input logic [XW-1:0]    lx0,
    input logic [XW-1:0]    lx1,
    input logic [YW-1:0]    ly0,
    input logic [YW-1:0]    ly1,
    input logic [XW-1:0]    x,
    input logic [YW-1:0]    y
  );
    logic [PIX_W+XW-1:0] gx;
    gx     = {{PIX_W{1'b0}}, x};
    pix_fn = f;
    unique case (m)
      MODE_SOLID: pix_fn = f;
      MODE_RECT:
        pix_fn = (x >= lx0 && x <= lx1 && y >= ly0 && y <= ly1) ? f : b;
`ifdef FILLER_CHECKER_EN
      MODE_CHECKER: pix_fn = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? f : b;
`else
      MODE_CHECKER: pix_fn = f;
`endif
      MODE_HGRAD: pix_fn = gx[PIX_W-1:0];
      default:    pix_fn = f;
    endcase
  endfunction

  // The start cycle renders pixel (0,0) from the live inputs being latched.
  assign ld     = (state_q == ST_IDLE) && start;
  assign acc    = we_q && wr_ready;
  assign mode_s = ld ? mode_e'(mode) : mode_q;
  assign fg_s   = ld ? fg : fg_q;
  assign bg_s   = ld ? bg : bg_q;
  assign x0_s   = ld ? x0 : x0_q;
  assign x1_s   = ld ? x1 : x1_q;
  assign y0_s   = ld ? y0 : y0_q;
  assign y1_s   = ld ? y1 : y1_q;

  raster_counter #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk_i   (clk_25),
    .rst_ni  (reset_n),
    .clr_i   (clr),
    .adv_i   (adv),
    .x_nxt_o (x_nxt),
    .y_nxt_o (y_nxt),
    .addr_o  (write_addr),
    .last_o  (last)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    adv      = 1'b0;
    clr      = 1'b0;
    load_pix = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FILL;
          clr      = 1'b1;
          we_d     = 1'b1;
          load_pix = 1'b1;
        end
      end
      ST_FILL: begin
        if (acc) begin
          adv = 1'b1;
          if (last) begin
            state_d = ST_DONE;
            we_d    = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            load_pix = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (cont) begin
          state_d  = ST_FILL;
          we_d     = 1'b1;
          load_pix = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pix_d = pix_q;
    if (load_pix) begin
      pix_d = pix_fn(mode_s, fg_s, bg_s, x0_s, x1_s, y0_s, y1_s,
                     x_nxt, y_nxt);
    end
  end

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_SOLID;
      fg_q    <= '0;
      bg_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      pix_q   <= pix_d;
      busy_q  <= (state_d == ST_FILL);
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      if (ld) begin
        mode_q <= mode_e'(mode);
        fg_q   <= fg;
        bg_q   <= bg;
        x0_q   <= x0;
        x1_q   <= x1;
        y0_q   <= y0;
        y1_q   <= y1;
      end
    end
  end

  assign we        = we_q;
  assign pixel     = pix_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = cnt_q;

endmodule
